load_scoreboard: RTL and testbench

Tracks outstanding loads between the decode stage and the LSU writeback. It keeps a per-register busy bitmap and an outstanding-load counter, and raises a stall toward decode when the instruction being decoded reads a register still awaiting load data. It also stalls when the LSU outstanding budget is exhausted. It sits beside decode, between the fetch/decode handshake and the execute issue point, and retires entries from the MEM/WB writeback interface.

---
 rtl/load_scoreboard_pkg.sv | 9 +
 rtl/load_pending_cnt.sv | 35 +++
 rtl/load_scoreboard.sv | 104 ++++++++++
 tb/tb_load_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_scoreboard_pkg.sv
// Shared register-index and busy-bitmap types for the load scoreboard.
package load_scoreboard_pkg;

  localparam int RV_REG_NUM = 32;

  typedef logic [4:0]            raddr_t;
  typedef logic [RV_REG_NUM-1:0] busy_map_t;

endpackage

// File: rtl/load_pending_cnt.sv
// Saturating up/down count of loads in flight, with underflow/overflow flags
// for the sticky error in the scoreboard.
module load_pending_cnt #(
  parameter int  NUM_PENDING = 2,
  localparam int CW          = $clog2(NUM_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          underflow,
  output logic          overflow
);

  logic [CW-1:0] count_ff;

  assign count     = count_ff;
  assign full      = (count_ff == CW'(NUM_PENDING));
  assign underflow = dec && (count_ff == '0);
  assign overflow  = inc && !dec && full;

  // Simultaneous inc/dec cancels; otherwise clamp to [0, NUM_PENDING].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_ff <= '0;
    end else if (inc && !dec && !full) begin
      count_ff <= count_ff + CW'(1);
    end else if (dec && !inc && (count_ff != '0)) begin
      count_ff <= count_ff - CW'(1);
    end
  end

endmodule

// File: rtl/load_scoreboard.sv
// Load scoreboard: busy bitmap plus outstanding-load budget, stalls decode on
// load-use hazards. Define NOX_STALL_CNT_EN to add the stall_cnt_o counter.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int  NUM_PENDING = 2,
  parameter int  REG_NUM     = RV_REG_NUM,
  localparam int CW          = $clog2(NUM_PENDING + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid_i,
  input  logic               issue_load_i,
  input  logic [4:0]         issue_rd_i,
  input  logic [4:0]         dec_rs1_i,
  input  logic [4:0]         dec_rs2_i,
  input  logic               dec_rs1_used_i,
  input  logic               dec_rs2_used_i,
  input  logic               flush_i,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_rd_i,
  output logic               stall_o,
  output logic               full_o,
  output logic [CW-1:0]      pending_o,
  output logic [REG_NUM-1:0] busy_o,
  output logic               err_o
`ifdef NOX_STALL_CNT_EN
  , output logic [31:0]      stall_cnt_o
`endif
);

  logic               issue_eff;
  logic               stall;
  logic               full;
  logic               underflow;
  logic               overflow;
  logic               err_ff;
  logic [REG_NUM-1:0] busy_ff;
  logic [REG_NUM-1:0] busy_nxt;

  assign issue_eff = issue_valid_i && issue_load_i && !flush_i;

  load_pending_cnt #(
    .NUM_PENDING (NUM_PENDING)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (issue_eff),
    .dec       (wb_valid_i),
    .count     (pending_o),
    .full      (full),
    .underflow (underflow),
    .overflow  (overflow)
  );

  // Stall looks only at registered state; a same-cycle writeback never bypasses.
  assign stall = (dec_rs1_used_i && busy_ff[dec_rs1_i]) ||
                 (dec_rs2_used_i && busy_ff[dec_rs2_i]) ||
                 full;

  // Clear before set so a same-register issue keeps the bit busy.
  always_comb begin
    busy_nxt = busy_ff;
    if (wb_valid_i) begin
      busy_nxt[wb_rd_i] = 1'b0;
    end
    if (issue_eff && (issue_rd_i != 5'd0)) begin
      busy_nxt[issue_rd_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_ff <= '0;
      err_ff  <= 1'b0;
    end else begin
      busy_ff <= busy_nxt;
      if (underflow || overflow || (issue_valid_i && stall)) begin
        err_ff <= 1'b1;
      end
    end
  end

  assign stall_o = stall;
  assign full_o  = full;
  assign busy_o  = busy_ff;
  assign err_o   = err_ff;

`ifdef NOX_STALL_CNT_EN
  logic [31:0] stall_cnt_ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_ff <= '0;
    end else if (stall) begin
      stall_cnt_ff <= stall_cnt_ff + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_ff;
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
// Self-checking bench for load_scoreboard against a behavioural model.
module tb_load_scoreboard;

  localparam int NP = 2;
  localparam int CW = $clog2(NP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid_i, issue_load_i, flush_i, wb_valid_i;
  logic [4:0]    issue_rd_i, dec_rs1_i, dec_rs2_i, wb_rd_i;
  logic          dec_rs1_used_i, dec_rs2_used_i;
  logic          stall_o, full_o, err_o;
  logic [CW-1:0] pending_o;
  logic [31:0]   busy_o;
`ifdef NOX_STALL_CNT_EN
  logic [31:0]   stall_cnt_o;
`endif

  load_scoreboard #(.NUM_PENDING(NP), .REG_NUM(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid_i  (issue_valid_i),
    .issue_load_i   (issue_load_i),
    .issue_rd_i     (issue_rd_i),
    .dec_rs1_i      (dec_rs1_i),
    .dec_rs2_i      (dec_rs2_i),
    .dec_rs1_used_i (dec_rs1_used_i),
    .dec_rs2_used_i (dec_rs2_used_i),
    .flush_i        (flush_i),
    .wb_valid_i     (wb_valid_i),
    .wb_rd_i        (wb_rd_i),
    .stall_o        (stall_o),
    .full_o         (full_o),
    .pending_o      (pending_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
`ifdef NOX_STALL_CNT_EN
    , .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: registers awaiting data, loads in flight, error flag.
  bit          busy_m[32];
  int          pend_m;
  bit          err_m;
  int unsigned scnt_m;
  int          q[$];

  function automatic bit stall_exp();
    return (dec_rs1_used_i && busy_m[dec_rs1_i]) ||
           (dec_rs2_used_i && busy_m[dec_rs2_i]) ||
           (pend_m == NP);
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    pend_m = 0;
    err_m  = 1'b0;
    scnt_m = 0;
    q.delete();
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_load_i = 0; issue_rd_i = 0; flush_i = 0;
    wb_valid_i = 0; wb_rd_i = 0;
    dec_rs1_i = 0; dec_rs2_i = 0; dec_rs1_used_i = 0; dec_rs2_used_i = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid_i = 1; issue_load_i = 1; issue_rd_i = rd;
  endtask

  task automatic tick();
    bit s, eff;
    @(posedge clk);
    s   = stall_exp();
    eff = issue_valid_i && issue_load_i && !flush_i;
    if (wb_valid_i && pend_m == 0) err_m = 1'b1;
    if (eff && pend_m == NP && !wb_valid_i) err_m = 1'b1;
    if (issue_valid_i && s) err_m = 1'b1;
    if (eff && !wb_valid_i) pend_m = (pend_m == NP) ? NP : pend_m + 1;
    else if (wb_valid_i && !eff && pend_m > 0) pend_m = pend_m - 1;
    if (wb_valid_i) busy_m[wb_rd_i] = 1'b0;
    if (eff && issue_rd_i != 0) busy_m[issue_rd_i] = 1'b1;
    if (s) scnt_m = scnt_m + 1;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) tick();
    total++; if (busy_o !== 32'd0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy_o); end
    total++; if (pending_o !== '0) begin bad++; $display("FAIL reset_pending: got %0d want 0", pending_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err_o); end
    total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", full_o); end
  endtask

  task automatic test_dependency();
    do_reset();
    issue(5);
    tick();
    idle(); dec_rs1_i = 5; dec_rs1_used_i = 1;
    #1;
    total++; if (stall_o !== stall_exp()) begin bad++; $display("FAIL dep_stall: got %0b want %0b", stall_o, stall_exp()); end
    repeat (2) tick();
    wb_valid_i = 1; wb_rd_i = 5;
    #1;
    total++; if (stall_o !== stall_exp()) begin bad++; $display("FAIL dep_no_bypass: got %0b want %0b", stall_o, stall_exp()); end
    tick();
    wb_valid_i = 0;
    #1;
    total++; if (stall_o !== stall_exp()) begin bad++; $display("FAIL dep_release: got %0b want %0b", stall_o, stall_exp()); end
    total++; if (busy_o !== busy_vec()) begin bad++; $display("FAIL dep_busy: got %h want %h", busy_o, busy_vec()); end
    total++; if (err_o !== err_m) begin bad++; $display("FAIL dep_err: got %0b want %0b", err_o, err_m); end
  endtask

  task automatic test_full();
    do_reset();
    issue(3); tick();
    issue(4); tick();
    idle(); dec_rs1_i = 7; dec_rs1_used_i = 1;
    #1;
    total++; if (full_o !== (pend_m == NP)) begin bad++; $display("FAIL full_set: got %0b want %0b", full_o, pend_m == NP); end
    total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL full_pending: got %0d want %0d", pending_o, pend_m); end
    total++; if (stall_o !== stall_exp()) begin bad++; $display("FAIL full_stall: got %0b want %0b", stall_o, stall_exp()); end
    wb_valid_i = 1; wb_rd_i = 3;
    tick();
    wb_valid_i = 0;
    #1;
    total++; if (full_o !== (pend_m == NP)) begin bad++; $display("FAIL full_clear: got %0b want %0b", full_o, pend_m == NP); end
    total++; if (stall_o !== stall_exp()) begin bad++; $display("FAIL full_release: got %0b want %0b", stall_o, stall_exp()); end
    total++; if (busy_o !== busy_vec()) begin bad++; $display("FAIL full_busy: got %h want %h", busy_o, busy_vec()); end
  endtask

  task automatic test_overflow();
    do_reset();
    issue(3); tick();
    issue(4); tick();
    issue(8); tick();
    idle();
    total++; if (err_o !== err_m) begin bad++; $display("FAIL ovf_err: got %0b want %0b", err_o, err_m); end
    total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL ovf_pending: got %0d want %0d", pending_o, pend_m); end
    total++; if (busy_o !== busy_vec()) begin bad++; $display("FAIL ovf_busy: got %h want %h", busy_o, busy_vec()); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue(6); tick();
    issue(6); wb_valid_i = 1; wb_rd_i = 6;
    tick();
    idle();
    total++; if (busy_o !== busy_vec()) begin bad++; $display("FAIL same_busy: got %h want %h", busy_o, busy_vec()); end
    total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL same_pending: got %0d want %0d", pending_o, pend_m); end
    wb_valid_i = 1; wb_rd_i = 6;
    tick();
    idle();
    total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL same_drain: got %0d want %0d", pending_o, pend_m); end
    total++; if (err_o !== err_m) begin bad++; $display("FAIL same_err: got %0b want %0b", err_o, err_m); end
  endtask

  task automatic test_rd0_flush();
    do_reset();
    issue(0); tick();
    idle();
    total++; if (busy_o !== busy_vec()) begin bad++; $display("FAIL rd0_busy: got %h want %h", busy_o, busy_vec()); end
    total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL rd0_pending: got %0d want %0d", pending_o, pend_m); end
    issue(9); flush_i = 1;
    tick();
    idle();
    total++; if (busy_o !== busy_vec()) begin bad++; $display("FAIL flush_busy: got %h want %h", busy_o, busy_vec()); end
    total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL flush_pending: got %0d want %0d", pending_o, pend_m); end
  endtask

  task automatic test_underflow();
    do_reset();
    wb_valid_i = 1; wb_rd_i = 12;
    tick();
    idle();
    total++; if (err_o !== err_m) begin bad++; $display("FAIL unf_err: got %0b want %0b", err_o, err_m); end
    total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL unf_pending: got %0d want %0d", pending_o, pend_m); end
    repeat (3) tick();
    total++; if (err_o !== err_m) begin bad++; $display("FAIL unf_sticky: got %0b want %0b", err_o, err_m); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(2); tick();
    idle(); dec_rs1_i = 2; dec_rs1_used_i = 1;
    tick();
`ifdef NOX_STALL_CNT_EN
    tick(); tick();
    total++; if (stall_cnt_o !== scnt_m) begin bad++; $display("FAIL scnt_three: got %0d want %0d", stall_cnt_o, scnt_m); end
`endif
    #2 rst = 1'b0;
    model_reset();
    #1;
    total++; if (stall_o !== stall_exp()) begin bad++; $display("FAIL arst_stall: got %0b want %0b", stall_o, stall_exp()); end
    total++; if (busy_o !== busy_vec()) begin bad++; $display("FAIL arst_busy: got %h want %h", busy_o, busy_vec()); end
    total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL arst_pending: got %0d want %0d", pending_o, pend_m); end
`ifdef NOX_STALL_CNT_EN
    total++; if (stall_cnt_o !== scnt_m) begin bad++; $display("FAIL arst_scnt: got %0d want %0d", stall_cnt_o, scnt_m); end
`endif
    #2 rst = 1'b1;
    idle();
    @(negedge clk);
    wb_valid_i = 1; wb_rd_i = 2;
    tick();
    idle();
    total++; if (err_o !== err_m) begin bad++; $display("FAIL arst_stale_wb: got %0b want %0b", err_o, err_m); end
  endtask

  task automatic test_random();
    bit s;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      idle();
      dec_rs1_i      = 5'($urandom_range(0, 7));
      dec_rs2_i      = 5'($urandom_range(0, 7));
      dec_rs1_used_i = 1'($urandom_range(0, 1));
      dec_rs2_used_i = 1'($urandom_range(0, 1));
      s = stall_exp();
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        wb_valid_i = 1;
        wb_rd_i    = 5'(q.pop_front());
      end
      issue_valid_i = !s && ($urandom_range(0, 1) == 1);
      issue_load_i  = ($urandom_range(0, 3) != 0);
      issue_rd_i    = 5'($urandom_range(0, 7));
      flush_i       = ($urandom_range(0, 7) == 0);
      if (issue_valid_i && issue_load_i && !flush_i) q.push_back(int'(issue_rd_i));
      #1;
      total++; if (stall_o !== stall_exp()) begin bad++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, stall_o, stall_exp()); end
      tick();
      total++; if (busy_o !== busy_vec()) begin bad++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy_o, busy_vec()); end
      total++; if (pending_o !== CW'(pend_m)) begin bad++; $display("FAIL rnd_pending[%0d]: got %0d want %0d", n, pending_o, pend_m); end
      total++; if (full_o !== (pend_m == NP)) begin bad++; $display("FAIL rnd_full[%0d]: got %0b want %0b", n, full_o, pend_m == NP); end
      total++; if (err_o !== err_m) begin bad++; $display("FAIL rnd_err[%0d]: got %0b want %0b", n, err_o, err_m); end
`ifdef NOX_STALL_CNT_EN
      total++; if (stall_cnt_o !== scnt_m) begin bad++; $display("FAIL rnd_scnt[%0d]: got %0d want %0d", n, stall_cnt_o, scnt_m); end
`endif
    end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    test_reset();
    test_dependency();
    test_full();
    test_overflow();
    test_same_cycle();
    test_rd0_flush();
    test_underflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
